// File: rtl/upe_pkg.sv
// Shared UPE definitions: re-sign mode encoding and binary64 field positions.
package upe_pkg;

  typedef enum logic [1:0] {
    UPE_RS_SET = 2'd0,
    UPE_RS_NEG = 2'd1,
    UPE_RS_ABS = 2'd2,
    UPE_RS_XOR = 2'd3
  } upe_rs_mode_e;

  localparam int unsigned FP64_SIGN_BIT = 63;
  localparam int unsigned FP64_EXP_MSB  = 62;
  localparam int unsigned FP64_EXP_LSB  = 52;
  localparam int unsigned FP64_MANT_MSB = 51;
  localparam logic [10:0] FP64_EXP_ALL1 = 11'h7FF;

endpackage

// File: rtl/upe_fp64_classify.sv
// Combinational binary64 class decode (zero / inf / nan), sign ignored.
// Built only when UPE_RESIGN_CLASSIFY_EN is defined.
`ifdef UPE_RESIGN_CLASSIFY_EN
module upe_fp64_classify
  import upe_pkg::*;
(
  input  logic [63:0] value_i,
  output logic        is_zero_o,
  output logic        is_inf_o,
  output logic        is_nan_o
);

  logic [10:0] exp_field;
  logic        mant_nz;

  assign exp_field = value_i[FP64_EXP_MSB:FP64_EXP_LSB];
  assign mant_nz   = |value_i[FP64_MANT_MSB:0];

  assign is_zero_o = (exp_field == 11'h000) && !mant_nz;
  assign is_inf_o  = (exp_field == FP64_EXP_ALL1) && !mant_nz;
  assign is_nan_o  = (exp_field == FP64_EXP_ALL1) && mant_nz;

endmodule
`endif

// File: rtl/upe_resign_64u.sv
// Registered binary64 sign replace/flip/clear/XOR stage, 1-cycle latency.
// Optional Out classification flags under UPE_RESIGN_CLASSIFY_EN.
module upe_resign_64u
  import upe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] In,
  input  logic        sign,
  input  logic [1:0]  mode,
  input  logic        in_valid,
  output logic [63:0] Out,
  output logic        out_valid
`ifdef UPE_RESIGN_CLASSIFY_EN
  ,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
`endif
);

  logic        sign_res;
  logic [63:0] res;
  logic [63:0] out_d, out_q;
  logic        out_valid_q;

  // NOTE: combinational blocks assign a default first so no path leaves a latch.
  always_comb begin
    sign_res = sign;
    case (upe_rs_mode_e'(mode))
      UPE_RS_SET: sign_res = sign;
      UPE_RS_NEG: sign_res = ~In[FP64_SIGN_BIT];
      UPE_RS_ABS: sign_res = 1'b0;
      UPE_RS_XOR: sign_res = In[FP64_SIGN_BIT] ^ sign;
      default:    sign_res = sign;
    endcase
  end

  // Magnitude bits pass untouched, including NaN payloads and subnormals.
  assign res   = {sign_res, In[FP64_EXP_MSB:0]};
  assign out_d = in_valid ? res : out_q;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= 64'h0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= in_valid;
    end
  end

  assign Out       = out_q;
  assign out_valid = out_valid_q;

`ifdef UPE_RESIGN_CLASSIFY_EN
  logic cls_zero, cls_inf, cls_nan;
  logic is_zero_d, is_inf_d, is_nan_d;
  logic is_zero_q, is_inf_q, is_nan_q;

  // Classify the next-state word so the flags land in the same cycle as Out.
  upe_fp64_classify u_classify (
    .value_i   (res),
    .is_zero_o (cls_zero),
    .is_inf_o  (cls_inf),
    .is_nan_o  (cls_nan)
  );

  assign is_zero_d = in_valid ? cls_zero : is_zero_q;
  assign is_inf_d  = in_valid ? cls_inf  : is_inf_q;
  assign is_nan_d  = in_valid ? cls_nan  : is_nan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_zero_q <= 1'b1;
      is_inf_q  <= 1'b0;
      is_nan_q  <= 1'b0;
    end else begin
      is_zero_q <= is_zero_d;
      is_inf_q  <= is_inf_d;
      is_nan_q  <= is_nan_d;
    end
  end

  assign is_zero = is_zero_q;
  assign is_inf  = is_inf_q;
  assign is_nan  = is_nan_q;
`endif

endmodule

// File: tb/tb_upe_resign_64u.sv
// Directed, table-driven bench for upe_resign_64u; flag checks follow
// UPE_RESIGN_CLASSIFY_EN.
module tb_upe_resign_64u;
  import upe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [63:0] In;
  logic        sign;
  logic [1:0]  mode;
  logic        in_valid;
  logic [63:0] Out;
  logic        out_valid;
`ifdef UPE_RESIGN_CLASSIFY_EN
  logic        is_zero, is_inf, is_nan;
`endif

  int n_checks = 0;
  int n_errors = 0;

  upe_resign_64u dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .In        (In),
    .sign      (sign),
    .mode      (mode),
    .in_valid  (in_valid),
    .Out       (Out),
    .out_valid (out_valid)
`ifdef UPE_RESIGN_CLASSIFY_EN
    ,
    .is_zero   (is_zero),
    .is_inf    (is_inf),
    .is_nan    (is_nan)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] in;
    logic        sgn;
    logic [1:0]  md;
    logic [63:0] exp_out;
    logic        exp_z;
    logic        exp_i;
    logic        exp_n;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string name, input logic z, input logic i, input logic n);
`ifdef UPE_RESIGN_CLASSIFY_EN
    check({name, ".is_zero"}, {63'h0, is_zero}, {63'h0, z});
    check({name, ".is_inf"},  {63'h0, is_inf},  {63'h0, i});
    check({name, ".is_nan"},  {63'h0, is_nan},  {63'h0, n});
`endif
  endtask

  initial begin
    vecs[0]  = '{64'h5CD5153134D51531, 1'b0, UPE_RS_SET, 64'h5CD5153134D51531, 0, 0, 0};
    vecs[1]  = '{64'h5CD5153134D51531, 1'b1, UPE_RS_SET, 64'hDCD5153134D51531, 0, 0, 0};
    vecs[2]  = '{64'hDCD5153134D51531, 1'b1, UPE_RS_XOR, 64'h5CD5153134D51531, 0, 0, 0};
    vecs[3]  = '{64'h8000000000000000, 1'b1, UPE_RS_NEG, 64'h0000000000000000, 1, 0, 0};
    vecs[4]  = '{64'h3FF0000000000000, 1'b0, UPE_RS_NEG, 64'hBFF0000000000000, 0, 0, 0};
    vecs[5]  = '{64'hFFF8000000000001, 1'b1, UPE_RS_ABS, 64'h7FF8000000000001, 0, 0, 1};
    vecs[6]  = '{64'hFFF0000000000000, 1'b0, UPE_RS_ABS, 64'h7FF0000000000000, 0, 1, 0};
    vecs[7]  = '{64'h0123456789ABCDEF, 1'b1, UPE_RS_XOR, 64'h8123456789ABCDEF, 0, 0, 0};
    vecs[8]  = '{64'h0000000000000001, 1'b1, UPE_RS_SET, 64'h8000000000000001, 0, 0, 0};
    vecs[9]  = '{64'h7FF0000000000000, 1'b1, UPE_RS_NEG, 64'hFFF0000000000000, 0, 1, 0};
    vecs[10] = '{64'h8000000000000000, 1'b0, UPE_RS_XOR, 64'h8000000000000000, 1, 0, 0};

    rst_n = 1'b0; In = '0; sign = 1'b0; mode = UPE_RS_SET; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.Out", Out, 64'h0);
    check("reset.out_valid", {63'h0, out_valid}, 64'h0);
    check_flags("reset", 1, 0, 0);
    rst_n = 1'b1;

    // Single-shot vectors: valid pulse, then one idle cycle to see the hold.
    foreach (vecs[k]) begin
      @(negedge clk);
      In = vecs[k].in; sign = vecs[k].sgn; mode = vecs[k].md; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      In = ~vecs[k].in; sign = ~vecs[k].sgn;
      check($sformatf("vec%0d.Out", k), Out, vecs[k].exp_out);
      check($sformatf("vec%0d.out_valid", k), {63'h0, out_valid}, 64'h1);
      check_flags($sformatf("vec%0d", k), vecs[k].exp_z, vecs[k].exp_i, vecs[k].exp_n);
      @(negedge clk);
      check($sformatf("vec%0d.hold_Out", k), Out, vecs[k].exp_out);
      check($sformatf("vec%0d.hold_valid", k), {63'h0, out_valid}, 64'h0);
      check_flags($sformatf("vec%0d.hold", k), vecs[k].exp_z, vecs[k].exp_i, vecs[k].exp_n);
    end

    // Streaming: vectors 4..7 back to back, then idle.
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("stream%0d.Out", i - 1), Out, vecs[i + 3].exp_out);
        check($sformatf("stream%0d.out_valid", i - 1), {63'h0, out_valid}, 64'h1);
      end
      if (i < 4) begin
        In = vecs[i + 4].in; sign = vecs[i + 4].sgn; mode = vecs[i + 4].md; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("stream.hold_Out", Out, vecs[7].exp_out);
    check("stream.hold_valid", {63'h0, out_valid}, 64'h0);

    // Reset mid-stream, asserted between edges with in_valid high.
    @(negedge clk);
    In = vecs[6].in; sign = vecs[6].sgn; mode = vecs[6].md; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst.Out", Out, vecs[6].exp_out);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.Out", Out, 64'h0);
    check("mid_rst.out_valid", {63'h0, out_valid}, 64'h0);
    check_flags("mid_rst", 1, 0, 0);
    @(negedge clk);
    In = vecs[5].in; sign = vecs[5].sgn; mode = vecs[5].md;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst.Out", Out, vecs[5].exp_out);
    check("post_rst.out_valid", {63'h0, out_valid}, 64'h1);
    check_flags("post_rst", 0, 0, 1);
    @(negedge clk);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
